// File: rtl/serial_adder.sv
// Bit-serial adder: operands taken over a valid/ready handshake, summed LSB-first
// through one full_adder cell and a carry flop, result returned over a second handshake.

module full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] w_acc_nxt;
   logic             r_carry;
   logic [CW-1:0]    r_bit_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             w_s;
   logic             w_c;
   logic             w_last;

   full_adder u_fa (
      .i_a (r_a_sh[0]),
      .i_b (r_b_sh[0]),
      .i_c (r_carry),
      .o_s (w_s),
      .o_c (w_c)
   );

   // Sum bits shift into the vacated top of the A register, so it doubles as sum_sh.
   if (WIDTH == 1) begin : g_w1
      assign w_acc_nxt = w_s;
   end else begin : g_wn
      assign w_acc_nxt = {w_s, r_a_sh[WIDTH-1:1]};
   end

   assign w_last = (r_bit_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)  w_state_nxt = S_SHIFT;
         S_SHIFT: if (w_last)    w_state_nxt = S_DONE;
         S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
         default:                w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_sh    <= '0;
         r_b_sh    <= '0;
         r_carry   <= 1'b0;
         r_bit_cnt <= '0;
         r_sum     <= '0;
         r_cout    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a_sh    <= a;
                  r_b_sh    <= b;
                  r_carry   <= cin;
                  r_bit_cnt <= '0;
               end
            end
            S_SHIFT: begin
               r_a_sh    <= w_acc_nxt;
               r_b_sh    <= r_b_sh >> 1;
               r_carry   <= w_c;
               r_bit_cnt <= r_bit_cnt + 1'b1;
               if (w_last) begin
                  r_sum  <= w_acc_nxt;
                  r_cout <= w_c;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign sum       = r_sum;
   assign cout      = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table, corner sequences,
// random operands against an arithmetic model, and an exhaustive WIDTH=1 instance.

module tb_serial_adder;
   localparam int unsigned W = 8;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
   logic [W-1:0] a, b, sum;

   logic s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_cin, s_cout, s_busy;
   logic [0:0] s_a, s_b, s_sum;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(W)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .busy(busy)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .a(s_a), .b(s_b), .cin(s_cin), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .sum(s_sum), .cout(s_cout), .busy(s_busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      chk({name, "_in_ready"}, 32'(in_ready), 1);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic run_op(input string name, input logic [7:0] xa, input logic [7:0] xb,
                         input logic xc, input logic [7:0] esum, input logic ecout);
      int n;
      wait_ready(name);
      a = xa; b = xb; cin = xc; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      chk({name, "_busy"}, 32'(busy), 1);
      wait_valid(n);
      chk({name, "_latency"}, n, W);
      chk({name, "_sum"}, 32'(sum), 32'(esum));
      chk({name, "_cout"}, 32'(cout), 32'(ecout));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({name, "_drop_valid"}, 32'(out_valid), 0);
      chk({name, "_sum_held"}, 32'(sum), 32'(esum));
      chk({name, "_cout_held"}, 32'(cout), 32'(ecout));
   endtask

   vec_t vecs[7];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      int seen;
      logic [8:0] model;
      logic [1:0] m1;
      logic [7:0] ra, rb;
      logic rc;

      vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[1] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
      vecs[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
      vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[6] = '{8'h3C, 8'hC3, 1'b1, 8'h00, 1'b1};

      in_valid = 0; out_ready = 0; a = '0; b = '0; cin = 0;
      s_in_valid = 0; s_out_ready = 0; s_a = '0; s_b = '0; s_cin = 0;

      // Reset
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_sum", 32'(sum), 0);
      chk("rst_cout", 32'(cout), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_in_ready", 32'(in_ready), 1);

      // Directed table
      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);

      // Backpressure with in_valid held high throughout
      wait_ready("bp");
      a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
      tick();
      a = 8'h01; b = 8'h02; cin = 1'b1;
      wait_valid(n);
      chk("bp_latency", n, W);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("bp_valid%0d", k), 32'(out_valid), 1);
         chk($sformatf("bp_sum%0d", k), 32'(sum), 32'h46);
         chk($sformatf("bp_cout%0d", k), 32'(cout), 0);
         chk($sformatf("bp_in_ready%0d", k), 32'(in_ready), 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_drain_idle", 32'(busy), 0);
      chk("bp_drain_in_ready", 32'(in_ready), 1);
      chk("bp_drain_valid", 32'(out_valid), 0);
      tick();
      in_valid = 1'b0;
      chk("bp_second_accept", 32'(busy), 1);
      wait_valid(n);
      chk("bp2_latency", n, W);
      chk("bp2_sum", 32'(sum), 32'h04);
      chk("bp2_cout", 32'(cout), 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Reset during SHIFT at bit 3
      wait_ready("mid");
      a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_busy", 32'(busy), 0);
      chk("mid_in_ready", 32'(in_ready), 1);
      chk("mid_out_valid", 32'(out_valid), 0);
      chk("mid_sum", 32'(sum), 0);
      chk("mid_cout", 32'(cout), 0);
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (out_valid) seen++;
      end
      chk("mid_no_valid", seen, 0);
      run_op("post_mid", 8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0);

      // Random operands against arithmetic model
      for (int k = 0; k < 30; k++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         model = 9'(ra) + 9'(rb) + 9'(rc);
         run_op($sformatf("rnd%0d", k), ra, rb, rc, model[7:0], model[8]);
      end

      // WIDTH=1 exhaustive
      for (int i = 0; i < 8; i++) begin
         s_a = 1'(i >> 2); s_b = 1'(i >> 1); s_cin = 1'(i);
         m1 = 2'(s_a) + 2'(s_b) + 2'(s_cin);
         s_in_valid = 1'b1;
         tick();
         s_in_valid = 1'b0;
         n = 0;
         while (!s_out_valid && n < 20) begin
            tick();
            n++;
         end
         chk($sformatf("w1_lat%0d", i), n, 1);
         chk($sformatf("w1_sum%0d", i), 32'(s_sum), 32'(m1[0]));
         chk($sformatf("w1_cout%0d", i), 32'(s_cout), 32'(m1[1]));
         s_out_ready = 1'b1;
         tick();
         s_out_ready = 1'b0;
         chk($sformatf("w1_idle%0d", i), 32'(s_in_ready), 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
